// File: rtl/ts_pkg.sv
// ============================================================================
// Module   : ts_pkg
// Purpose  : Constants shared by the TS sync locker and the PID monitor:
//            the MPEG-TS sync byte, the nominal packet length, the locker
//            state encoding and a small packet-position helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ts_pkg;

  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  localparam int         TS_PKT_LEN   = 188;

  // Locker state encoding
  localparam int              ST_W      = 2;
  localparam logic [ST_W-1:0] ST_HUNT   = 2'd0;
  localparam logic [ST_W-1:0] ST_VERIFY = 2'd1;
  localparam logic [ST_W-1:0] ST_LOCKED = 2'd2;

  // Byte index of the next byte within a packet; wraps after last_pos.
  function automatic logic [7:0] pos_advance(input logic [7:0] pos,
                                             input logic [7:0] last_pos);
    return (pos == last_pos) ? 8'd0 : pos + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ts_sync_locker_sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Purpose  : Saturating up-counter with synchronous clear. A clear in the
//            same cycle as an increment wins and yields zero.
// Ports    : S_AXI_ACLK    - clock
//            S_AXI_ARESETN - synchronous active-low reset
//            inc           - count one event
//            clr           - synchronous clear (priority over inc)
//            count         - current value, sticks at all-ones
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             S_AXI_ACLK,
  input  logic             S_AXI_ARESETN,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/ts_sync_locker.sv
// ============================================================================
// Module   : ts_sync_locker
// Purpose  : Recovers MPEG-TS packet alignment from an unframed byte stream
//            by hunting for the sync byte at PKT_LEN intervals, then emits a
//            framed stream (data/valid/sync) with one cycle of latency.
//            Once locked it flywheels through corrupted sync bytes until
//            UNLOCK_COUNT consecutive misses are seen.
// Ports    : S_AXI_ACLK     - clock (rising edge)
//            S_AXI_ARESETN  - synchronous active-low reset
//            run_enable     - 0 forces HUNT and blocks output
//            counter_clear  - synchronous clear of both counters
//            ts_data/valid  - raw input byte and qualifier
//            mpeg_data/valid/sync - framed output stream
//            locked         - registered copy of (state == LOCKED)
//            lock_lost      - one-cycle pulse when misses drop the lock
//            pkt_count      - emitted packet starts (saturating)
//            sync_err_count - missed sync bytes while locked (saturating)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ts_sync_locker
  import ts_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int PKT_LEN            = TS_PKT_LEN,
  parameter int LOCK_COUNT         = 3,
  parameter int UNLOCK_COUNT       = 3
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic                          run_enable,
  input  logic                          counter_clear,
  input  logic [7:0]                    ts_data,
  input  logic                          ts_valid,
  output logic [7:0]                    mpeg_data,
  output logic                          mpeg_valid,
  output logic                          mpeg_sync,
  output logic                          locked,
  output logic                          lock_lost,
  output logic [C_S_AXI_DATA_WIDTH-1:0] pkt_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0] sync_err_count
);

  localparam logic [7:0] c_last_pos   = 8'(PKT_LEN - 1);
  localparam logic [4:0] c_lock_cnt   = 5'(LOCK_COUNT);
  localparam logic [4:0] c_unlock_cnt = 5'(UNLOCK_COUNT);

  logic [ST_W-1:0] r_state;
  logic [7:0]      r_pos;
  logic [3:0]      r_good_cnt;
  logic [3:0]      r_miss_cnt;
  logic [7:0]      r_mpeg_data;
  logic            r_mpeg_valid;
  logic            r_mpeg_sync;
  logic            r_locked;
  logic            r_lock_lost;

  logic            w_step;
  logic            w_is_sync;
  logic            w_at_start;
  logic [4:0]      w_good_next;
  logic [4:0]      w_miss_next;
  logic            w_enter_lock;
  logic            w_miss;
  logic            w_unlock;
  logic            w_emit;
  logic            w_pkt_inc;
  logic [7:0]      w_pos_next;

  // Per-byte decode. Counts are widened by one bit so the threshold compare
  // cannot wrap even at the 15 upper limit.
  always_comb begin
    w_step       = run_enable && ts_valid;
    w_is_sync    = (ts_data == TS_SYNC_BYTE);
    w_at_start   = (r_pos == 8'd0);
    w_good_next  = {1'b0, r_good_cnt} + 5'd1;
    w_miss_next  = {1'b0, r_miss_cnt} + 5'd1;
    w_enter_lock = w_step && (r_state == ST_VERIFY) && w_at_start &&
                   w_is_sync && (w_good_next >= c_lock_cnt);
    w_miss       = w_step && (r_state == ST_LOCKED) && w_at_start && !w_is_sync;
    w_unlock     = w_miss && (w_miss_next >= c_unlock_cnt);
    // The byte that completes verification is already the first framed byte.
    w_emit       = w_step && ((r_state == ST_LOCKED) || w_enter_lock);
    w_pkt_inc    = w_emit && w_at_start;
    w_pos_next   = pos_advance(r_pos, c_last_pos);
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_state      <= ST_HUNT;
      r_pos        <= 8'd0;
      r_good_cnt   <= 4'd0;
      r_miss_cnt   <= 4'd0;
      r_mpeg_data  <= 8'd0;
      r_mpeg_valid <= 1'b0;
      r_mpeg_sync  <= 1'b0;
      r_locked     <= 1'b0;
      r_lock_lost  <= 1'b0;
    end else begin
      r_lock_lost  <= w_unlock;
      // Lags the state by one edge; dropping run_enable clears it at once.
      r_locked     <= run_enable && (r_state == ST_LOCKED);
      r_mpeg_valid <= w_emit;
      r_mpeg_sync  <= w_pkt_inc;
      if (w_emit) begin
        r_mpeg_data <= ts_data;
      end

      if (!run_enable) begin
        r_state    <= ST_HUNT;
        r_pos      <= 8'd0;
        r_good_cnt <= 4'd0;
        r_miss_cnt <= 4'd0;
      end else if (ts_valid) begin
        case (r_state)
          ST_HUNT: begin
            if (w_is_sync) begin
              // A single required sync locks immediately; the candidate
              // itself is not emitted in that case.
              r_state    <= (LOCK_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
              r_pos      <= 8'd1;
              r_good_cnt <= 4'd1;
              r_miss_cnt <= 4'd0;
            end
          end

          ST_VERIFY: begin
            if (!w_at_start) begin
              r_pos <= w_pos_next;
            end else if (w_is_sync) begin
              r_pos      <= w_pos_next;
              r_good_cnt <= w_good_next[3:0];
              if (w_enter_lock) begin
                r_state    <= ST_LOCKED;
                r_miss_cnt <= 4'd0;
              end
            end else begin
              // Failed candidate: later bytes are hunted from scratch.
              r_state    <= ST_HUNT;
              r_pos      <= 8'd0;
              r_good_cnt <= 4'd0;
            end
          end

          ST_LOCKED: begin
            if (w_unlock) begin
              r_state    <= ST_HUNT;
              r_pos      <= 8'd0;
              r_good_cnt <= 4'd0;
              r_miss_cnt <= 4'd0;
            end else begin
              r_pos <= w_pos_next;
              if (w_at_start) begin
                r_miss_cnt <= w_is_sync ? 4'd0 : w_miss_next[3:0];
              end
            end
          end

          default: begin
            r_state    <= ST_HUNT;
            r_pos      <= 8'd0;
            r_good_cnt <= 4'd0;
            r_miss_cnt <= 4'd0;
          end
        endcase
      end
    end
  end

  sat_counter #(
    .WIDTH (C_S_AXI_DATA_WIDTH)
  ) u_pkt_counter (
    .S_AXI_ACLK    (S_AXI_ACLK),
    .S_AXI_ARESETN (S_AXI_ARESETN),
    .inc           (w_pkt_inc),
    .clr           (counter_clear),
    .count         (pkt_count)
  );

  sat_counter #(
    .WIDTH (C_S_AXI_DATA_WIDTH)
  ) u_sync_err_counter (
    .S_AXI_ACLK    (S_AXI_ACLK),
    .S_AXI_ARESETN (S_AXI_ARESETN),
    .inc           (w_miss),
    .clr           (counter_clear),
    .count         (sync_err_count)
  );

  assign mpeg_data  = r_mpeg_data;
  assign mpeg_valid = r_mpeg_valid;
  assign mpeg_sync  = r_mpeg_sync;
  assign locked     = r_locked;
  assign lock_lost  = r_lock_lost;

endmodule

`default_nettype wire

// File: tb/tb_ts_sync_locker.sv
// ============================================================================
// Module   : tb_ts_sync_locker
// Purpose  : Self-checking bench for ts_sync_locker. A behavioural model
//            tracks the packet phase as (accepted byte index - anchor) mod
//            PKT_LEN and predicts every output each cycle; directed scenarios
//            add literal expectations, followed by a randomized stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ts_sync_locker;

  localparam int W            = 32;
  localparam int PKT_LEN      = 188;
  localparam int LOCK_COUNT   = 3;
  localparam int UNLOCK_COUNT = 3;
  localparam longint MAXV     = (64'd1 << W) - 1;

  logic          S_AXI_ACLK = 1'b0;
  logic          S_AXI_ARESETN;
  logic          run_enable;
  logic          counter_clear;
  logic [7:0]    ts_data;
  logic          ts_valid;
  logic [7:0]    mpeg_data;
  logic          mpeg_valid;
  logic          mpeg_sync;
  logic          locked;
  logic          lock_lost;
  logic [W-1:0]  pkt_count;
  logic [W-1:0]  sync_err_count;

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  ts_sync_locker #(
    .C_S_AXI_DATA_WIDTH (W),
    .PKT_LEN            (PKT_LEN),
    .LOCK_COUNT         (LOCK_COUNT),
    .UNLOCK_COUNT       (UNLOCK_COUNT)
  ) dut (
    .S_AXI_ACLK     (S_AXI_ACLK),
    .S_AXI_ARESETN  (S_AXI_ARESETN),
    .run_enable     (run_enable),
    .counter_clear  (counter_clear),
    .ts_data        (ts_data),
    .ts_valid       (ts_valid),
    .mpeg_data      (mpeg_data),
    .mpeg_valid     (mpeg_valid),
    .mpeg_sync      (mpeg_sync),
    .locked         (locked),
    .lock_lost      (lock_lost),
    .pkt_count      (pkt_count),
    .sync_err_count (sync_err_count)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_HUNT = 0, M_VERIFY = 1, M_LOCKED = 2;
  int     m_mode;
  longint m_n;        // bytes accepted since reset
  longint m_anchor;   // accepted-byte index of the packet start we follow
  int     m_hits, m_misses, m_phase;
  longint m_pkt, m_err;
  bit     m_emit, m_inc_p, m_inc_e, m_was_locked, m_is47;
  logic [7:0] e_data;
  bit     e_valid, e_sync, e_locked, e_lost;

  always @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      m_mode = M_HUNT; m_n = 0; m_anchor = 0; m_hits = 0; m_misses = 0;
      m_pkt = 0; m_err = 0;
      e_data = 8'h00; e_valid = 0; e_sync = 0; e_locked = 0; e_lost = 0;
    end else begin
      m_was_locked = (m_mode == M_LOCKED);
      e_valid = 0; e_sync = 0; e_lost = 0;
      m_emit = 0; m_inc_p = 0; m_inc_e = 0;
      if (!run_enable) begin
        m_mode = M_HUNT;
      end else if (ts_valid) begin
        m_is47  = (ts_data == 8'h47);
        m_phase = int'((m_n - m_anchor) % PKT_LEN);
        if (m_mode == M_HUNT) begin
          if (m_is47) begin
            m_anchor = m_n; m_hits = 1; m_misses = 0;
            m_mode = (LOCK_COUNT == 1) ? M_LOCKED : M_VERIFY;
          end
        end else if (m_mode == M_VERIFY) begin
          if (m_phase == 0) begin
            if (m_is47) begin
              m_hits++;
              if (m_hits >= LOCK_COUNT) begin
                m_mode = M_LOCKED; m_misses = 0; m_emit = 1;
              end
            end else begin
              m_mode = M_HUNT;
            end
          end
        end else begin
          m_emit = 1;
          if (m_phase == 0) begin
            if (m_is47) m_misses = 0;
            else begin
              m_misses++; m_inc_e = 1;
              if (m_misses >= UNLOCK_COUNT) begin
                m_mode = M_HUNT; e_lost = 1;
              end
            end
          end
        end
        if (m_emit) begin
          e_valid = 1; e_sync = (m_phase == 0); e_data = ts_data;
          m_inc_p = (m_phase == 0);
        end
        m_n++;
      end
      e_locked = run_enable && m_was_locked;
      if (counter_clear) begin
        m_pkt = 0; m_err = 0;
      end else begin
        if (m_inc_p && m_pkt < MAXV) m_pkt++;
        if (m_inc_e && m_err < MAXV) m_err++;
      end
    end
  end

  // ---------------- compare process + tallies ----------------
  bit         cmp_en = 0;
  int         sync_seen, lost_seen, valid_seen;
  bit         have_first;
  logic [7:0] first_data;
  logic [7:0] out_q[$];

  always @(negedge S_AXI_ACLK) begin
    if (cmp_en) begin
      check("mpeg_valid", 64'(mpeg_valid), 64'(e_valid));
      check("mpeg_sync", 64'(mpeg_sync), 64'(e_sync));
      check("mpeg_data", 64'(mpeg_data), 64'(e_data));
      check("locked", 64'(locked), 64'(e_locked));
      check("lock_lost", 64'(lock_lost), 64'(e_lost));
      check("pkt_count", 64'(pkt_count), 64'(m_pkt));
      check("sync_err_count", 64'(sync_err_count), 64'(m_err));
      if (mpeg_sync === 1'b1) sync_seen++;
      if (lock_lost === 1'b1) lost_seen++;
      if (mpeg_valid === 1'b1) begin
        valid_seen++;
        out_q.push_back(mpeg_data);
        if (!have_first) begin
          have_first = 1; first_data = mpeg_data;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  bit gap_mode = 0;
  int gphase   = 0;

  task automatic drive(input logic [7:0] d, input logic v);
    ts_data = d; ts_valid = v;
    @(posedge S_AXI_ACLK); #1;
  endtask

  function automatic logic [7:0] body();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == 8'h47) b = 8'h46;
    return b;
  endfunction

  // Byte with the repeating 1-0-0-1 valid pattern when gap_mode is set.
  task automatic send_byte(input logic [7:0] d);
    if (gap_mode) begin
      while ((gphase % 4 == 1) || (gphase % 4 == 2)) begin
        drive(8'($urandom), 1'b0); gphase++;
      end
    end
    drive(d, 1'b1); gphase++;
  endtask

  task automatic send_pkt(input logic [7:0] head);
    send_byte(head);
    for (int i = 1; i < PKT_LEN; i++) send_byte(body());
  endtask

  task automatic send_rand(input logic [7:0] d);
    counter_clear = ($urandom_range(0, 199) == 0);
    while ($urandom_range(0, 3) == 0) drive(8'($urandom), 1'b0);
    drive(d, 1'b1);
    counter_clear = 1'b0;
  endtask

  task automatic clear_tallies();
    sync_seen = 0; lost_seen = 0; valid_seen = 0; have_first = 0;
    first_data = 8'h00; out_q.delete();
  endtask

  task automatic do_reset();
    S_AXI_ARESETN = 1'b0; ts_valid = 1'b0; ts_data = 8'h00;
    run_enable = 1'b1; counter_clear = 1'b0;
    repeat (2) @(posedge S_AXI_ACLK);
    #1;
    clear_tallies();
    S_AXI_ARESETN = 1'b1;
  endtask

  logic [7:0] stream[$];
  int         snap, bad;

  initial begin
    S_AXI_ARESETN = 1'b0; run_enable = 1'b1; counter_clear = 1'b0;
    ts_data = 8'h00; ts_valid = 1'b0;
    do_reset();
    cmp_en = 1;
    check("reset_locked", 64'(locked), 64'd0);
    check("reset_pkt_count", 64'(pkt_count), 64'd0);

    // S1: five clean packets
    for (int p = 0; p < 5; p++) send_pkt(8'h47);
    check("s1_sync_pulses", 64'(sync_seen), 64'd3);
    check("s1_pkt_count", 64'(pkt_count), 64'd3);
    check("s1_err_count", 64'(sync_err_count), 64'd0);
    check("s1_locked", 64'(locked), 64'd1);
    check("s1_first_data", 64'(first_data), 64'h47);

    // S2: one corrupted sync, flywheel keeps lock
    send_pkt(8'h00);
    send_pkt(8'h47);
    send_pkt(8'h47);
    check("s2_err_count", 64'(sync_err_count), 64'd1);
    check("s2_pkt_count", 64'(pkt_count), 64'd6);
    check("s2_locked", 64'(locked), 64'd1);
    check("s2_lost", 64'(lost_seen), 64'd0);

    // S3: three consecutive misses drop the lock
    send_pkt(8'h00);
    send_pkt(8'h00);
    send_byte(8'h00);
    check("s3_lost_pulse", 64'(lock_lost), 64'd1);
    #5;
    check("s3_err_count", 64'(sync_err_count), 64'd4);
    snap = valid_seen;
    for (int i = 1; i < PKT_LEN + 5; i++) send_byte(body());
    #5;
    check("s3_no_valid_after", 64'(valid_seen), 64'(snap));
    check("s3_lost_once", 64'(lost_seen), 64'd1);
    check("s3_locked", 64'(locked), 64'd0);

    // S4: false candidate at byte 50, true phase at 100 + 188k
    do_reset();
    stream.delete();
    for (int i = 0; i < 100 + PKT_LEN * 6; i++) stream.push_back(body());
    stream[50] = 8'h47;
    for (int k = 0; k < 6; k++) stream[100 + PKT_LEN * k] = 8'h47;
    foreach (stream[i]) send_byte(stream[i]);
    check("s4_first_data", 64'(first_data), 64'h47);
    check("s4_pkt_count", 64'(pkt_count), 64'd3);
    check("s4_locked", 64'(locked), 64'd1);

    // S5: 1-0-0-1 valid gaps are transparent
    do_reset();
    stream.delete();
    for (int p = 0; p < 5; p++) begin
      stream.push_back(8'h47);
      for (int i = 1; i < PKT_LEN; i++) stream.push_back(body());
    end
    gap_mode = 1; gphase = 0;
    foreach (stream[i]) send_byte(stream[i]);
    gap_mode = 0;
    drive(8'h00, 1'b0);
    drive(8'h00, 1'b0);
    check("s5_out_len", 64'(out_q.size()), 64'(3 * PKT_LEN));
    bad = 0;
    for (int i = 0; i < out_q.size() && i < 3 * PKT_LEN; i++)
      if (out_q[i] !== stream[2 * PKT_LEN + i]) bad++;
    check("s5_out_bytes_bad", 64'(bad), 64'd0);
    check("s5_pkt_count", 64'(pkt_count), 64'd3);

    // S6: clear wins over increment, then run_enable drop
    do_reset();
    for (int p = 0; p < 3; p++) send_pkt(8'h47);
    check("s6_pkt_before", 64'(pkt_count), 64'd1);
    counter_clear = 1'b1;
    send_byte(8'h47);
    counter_clear = 1'b0;
    check("s6_clear_wins", 64'(pkt_count), 64'd0);
    for (int i = 1; i < PKT_LEN; i++) send_byte(body());
    send_byte(8'h00);
    for (int i = 0; i < 10; i++) send_byte(body());
    run_enable = 1'b0;
    send_byte(body());
    check("s6_locked_drop", 64'(locked), 64'd0);
    check("s6_no_lost", 64'(lock_lost), 64'd0);
    check("s6_no_valid", 64'(mpeg_valid), 64'd0);
    for (int i = 0; i < 200; i++) send_byte((i % 47 == 0) ? 8'h47 : body());
    check("s6_pkt_hold", 64'(pkt_count), 64'd1);
    check("s6_err_hold", 64'(sync_err_count), 64'd1);
    run_enable = 1'b1;

    // S7: randomized stream with corrupt syncs, slips, gaps, clears,
    //     a run_enable burst and a mid-packet reset
    do_reset();
    for (int p = 0; p < 24; p++) begin
      send_rand(($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h47);
      for (int i = 1; i < PKT_LEN; i++) begin
        send_rand(8'($urandom));
        if (p == 17 && i == 90) do_reset();
      end
      if ($urandom_range(0, 5) == 0) send_rand(8'($urandom));
      if (p == 10) begin
        run_enable = 1'b0;
        for (int i = 0; i < 20; i++) drive(8'($urandom), 1'($urandom));
        run_enable = 1'b1;
      end
    end
    drive(8'h00, 1'b0);
    drive(8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
